// File: rtl/inst_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
// Shared widths, state encodings and the prefetch-buffer entry type used by
// the instruction-fetch sequencer and its prefetch buffer.
//   inst_addr_bus   : instruction address width
//   inst_bus        : instruction word width
//   fetch_state_bus : width of the fetch FSM state register
//   zero_word       : all-zero instruction/address word
// -----------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

    localparam int inst_addr_bus   = 32;
    localparam int inst_bus        = 32;
    localparam int fetch_state_bus = 2;

    localparam logic [inst_bus-1:0] zero_word = 32'h0000_0000;

    typedef enum logic [fetch_state_bus-1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } fetch_state_t;

    // One prefetch-buffer entry: fetch address plus the word read there.
    typedef struct packed {
        logic [inst_addr_bus-1:0] pc;
        logic [inst_bus-1:0]      inst;
    } fetch_entry_t;

    // Sequential fetch address; 32'hFFFF_FFFC wraps naturally to zero.
    function automatic logic [inst_addr_bus-1:0] next_pc(input logic [inst_addr_bus-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry, 64-bit-wide synchronous FIFO holding {pc, inst} pairs between
// the fetch stage and decode. Flush wins over push; a pop in the flush cycle
// is legal and simply has no further effect.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write din (ignored when full without a simultaneous pop)
//   pop        : drop the head entry
//   flush      : empty the buffer
//   din        : entry to write
//   count      : number of valid entries (0..2)
//   head       : oldest entry, all zero when empty
// -----------------------------------------------------------------------------
module fetch_buf
    import inst_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entry0_r;
    fetch_entry_t entry1_r;
    logic [1:0]   count_r;

    // Storage and occupancy update; entry0_r is always the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= din;
                        count_r  <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        entry1_r <= din;
                        count_r  <= 2'd2;
                    end else begin
                        count_r  <= count_r;
                    end
                end
                2'b01: begin
                    if (count_r != 2'd0) begin
                        entry0_r <= entry1_r;
                        count_r  <= count_r - 2'd1;
                    end else begin
                        count_r  <= count_r;
                    end
                end
                2'b11: begin
                    case (count_r)
                        // Pop of an empty buffer is meaningless: push only.
                        2'd0: begin
                            entry0_r <= din;
                            count_r  <= 2'd1;
                        end
                        2'd1: begin
                            entry0_r <= din;
                        end
                        2'd2: begin
                            entry0_r <= entry1_r;
                            entry1_r <= din;
                        end
                        default: begin
                            count_r  <= 2'd0;
                        end
                    endcase
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Head presentation; zero when nothing is buffered.
    always_comb begin
        head = '0;
        if (count_r != 2'd0) begin
            head = entry0_r;
        end else begin
            head = '0;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Instruction-fetch sequencer: owns the PC, drives the instruction ROM
// (combinational read), captures {pc, inst} into a 2-entry prefetch buffer
// drained by decode through valid/ready, and handles redirects and halts.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target raises sticky
//               misalign_o and blocks fetch until an aligned redirect.
//   undefined : redirect target bits [1:0] are forced to zero and
//               misalign_o is constant 0.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   halt_i              : stop issuing fetches (buffer keeps draining)
//   redirect_i          : flush buffer, restart fetch at redirect_pc_i
//   redirect_pc_i       : redirect target
//   rom_ce_o, rom_addr_o: ROM chip-enable and byte address (0 when idle)
//   rom_inst_i          : ROM read data
//   if_valid_o/ready_i  : decode handshake on the buffer head
//   if_pc_o, if_inst_o  : head entry (0 when empty)
//   misalign_o          : misaligned-redirect fault
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [inst_addr_bus-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     halt_i,
    input  logic                     redirect_i,
    input  logic [inst_addr_bus-1:0] redirect_pc_i,
    output logic                     rom_ce_o,
    output logic [inst_addr_bus-1:0] rom_addr_o,
    input  logic [inst_bus-1:0]      rom_inst_i,
    output logic                     if_valid_o,
    input  logic                     if_ready_i,
    output logic [inst_addr_bus-1:0] if_pc_o,
    output logic [inst_bus-1:0]      if_inst_o,
    output logic                     misalign_o
);

    fetch_state_t             state_r;
    fetch_state_t             state_nxt_s;
    logic [inst_addr_bus-1:0] pc_r;
    logic [inst_addr_bus-1:0] redir_target_s;
    logic                     fetch_block_s;
    logic                     fetch_s;
    logic                     pop_s;
    logic                     valid_s;
    logic [1:0]               count_s;
    fetch_entry_t             push_entry_s;
    fetch_entry_t             head_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_r;

    assign redir_target_s = redirect_pc_i;
    assign fetch_block_s  = misalign_r;

    // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else if (redirect_i) begin
            misalign_r <= (redirect_pc_i[1:0] != 2'b00);
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign misalign_o = misalign_r;
`else
    assign redir_target_s = redirect_pc_i & 32'hFFFF_FFFC;
    assign fetch_block_s  = 1'b0;
    assign misalign_o     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; redirects never change the state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (halt_i) begin
                    state_nxt_s = S_HALT;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_i) begin
                    state_nxt_s = S_HALT;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_HALT: begin
                if (!halt_i) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_HALT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Handshake and fetch decision. halt_i gates fetch combinationally so
    // no fetch is issued in the cycle halt is first seen.
    always_comb begin
        valid_s = 1'b0;
        pop_s   = 1'b0;
        fetch_s = 1'b0;
        valid_s = (count_s != 2'd0);
        pop_s   = valid_s && if_ready_i;
        if ((state_r == S_RUN) && !halt_i && !redirect_i && !fetch_block_s) begin
            fetch_s = (count_s < 2'd2) || pop_s;
        end else begin
            fetch_s = 1'b0;
        end
    end

    // Program counter: redirect beats sequential advance; held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_i) begin
            pc_r <= redir_target_s;
        end else if (fetch_s) begin
            pc_r <= next_pc(pc_r);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign push_entry_s = '{pc: pc_r, inst: rom_inst_i};

    fetch_buf u_fetch_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fetch_s),
        .pop   (pop_s),
        .flush (redirect_i),
        .din   (push_entry_s),
        .count (count_s),
        .head  (head_s)
    );

    assign rom_ce_o   = fetch_s;
    assign rom_addr_o = fetch_s ? pc_r : zero_word;
    assign if_valid_o = valid_s;
    assign if_pc_o    = head_s.pc;
    assign if_inst_o  = head_s.inst;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
// Cycle table for start-up, back-pressure, redirect and halt, plus hand
// sequences for PC wrap, asynchronous reset and misaligned redirects. Every
// decode handshake is checked against a queue of expected PCs.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        halt_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        halt;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ce;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] hpc;
    } vec_t;

    vec_t vecs[23];

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .halt_i        (halt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .rom_ce_o      (rom_ce_o),
        .rom_addr_o    (rom_addr_o),
        .rom_inst_i    (rom_inst_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM word k holds 0x1000_0000 + k.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    function automatic vec_t mk(input logic h, input logic r, input logic [31:0] p,
                                input logic y, input logic c, input logic [31:0] a,
                                input logic v, input logic [31:0] hp);
        vec_t t;
        t.halt = h; t.redir = r; t.rpc = p; t.rdy = y;
        t.ce = c; t.addr = a; t.vld = v; t.hpc = hp;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and move to the sampling point.
    task automatic step(input logic h, input logic r, input logic [31:0] p, input logic y);
        halt_i        = h;
        redirect_i    = r;
        redirect_pc_i = p;
        if_ready_i    = y;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Assert reset (asynchronously) and release it just after a rising edge.
    task automatic do_reset();
        rst_n         = 1'b0;
        halt_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        if_ready_i    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ce"},    {31'd0, rom_ce_o},   32'd0);
        chk({tag, "_addr"},  rom_addr_o,          32'd0);
        chk({tag, "_valid"}, {31'd0, if_valid_o}, 32'd0);
        chk({tag, "_pc"},    if_pc_o,             32'd0);
        chk({tag, "_inst"},  if_inst_o,           32'd0);
        chk({tag, "_mis"},   {31'd0, misalign_o}, 32'd0);
    endtask

    // Scoreboard: every accepted head must match the next expected PC.
    always @(negedge clk) begin
        if (rst_n && if_valid_o && if_ready_i) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: unexpected head pc %h", if_pc_o);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                chk("sb_pc", if_pc_o, e);
                chk("sb_inst", if_inst_o, rom_word(e));
            end
        end
    end

    initial begin
        // Start-up with stall, drain, redirect under full buffer, halt,
        // redirect while halted.
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b1, 32'h0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h0);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h0);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h0);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h4);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h8);
        vecs[8]  = mk(1'b0, 1'b1, 32'h40,  1'b1, 1'b0, 32'h0,   1'b1, 32'hC);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  1'b0, 32'h0);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  1'b1, 32'h40);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h48,  1'b1, 32'h44);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h48);
        vecs[13] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
        vecs[14] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
        vecs[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4C,  1'b0, 32'h0);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h50,  1'b1, 32'h4C);
        vecs[18] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h50);
        vecs[19] = mk(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
        vecs[21] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
        vecs[22] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h100);

        // Reset values while reset is held.
        rst_n         = 1'b0;
        halt_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        if_ready_i    = 1'b0;
        #3;
        chk_zero_outputs("reset");

        // ---- table run ----
        sb_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h100};
        do_reset();
        for (int i = 0; i < 23; i++) begin
            step(vecs[i].halt, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("v%0d_ce", i),    {31'd0, rom_ce_o},   {31'd0, vecs[i].ce});
            chk($sformatf("v%0d_addr", i),  rom_addr_o,          vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, if_valid_o}, {31'd0, vecs[i].vld});
            chk($sformatf("v%0d_pc", i),    if_pc_o,             vecs[i].hpc);
            chk($sformatf("v%0d_inst", i),  if_inst_o,
                vecs[i].vld ? rom_word(vecs[i].hpc) : 32'h0);
            chk($sformatf("v%0d_mis", i),   {31'd0, misalign_o}, 32'd0);
            adv();
        end

        // ---- PC wrap at 0xFFFF_FFFC, then asynchronous reset ----
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst1");
        sb_q.push_back(32'h0);
        sb_q.push_back(32'hFFFF_FFF8);
        sb_q.push_back(32'hFFFF_FFFC);
        sb_q.push_back(32'h0);
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_c0_ce", {31'd0, rom_ce_o}, 32'd0);
        adv();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_c1_addr", rom_addr_o, 32'h0);
        adv();
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        chk("wrap_redir_ce", {31'd0, rom_ce_o}, 32'd0);
        adv();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_c3_addr", rom_addr_o, 32'hFFFF_FFF8);
        adv();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_c4_addr", rom_addr_o, 32'hFFFF_FFFC);
        adv();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_c5_ce", {31'd0, rom_ce_o}, 32'd1);
        chk("wrap_c5_addr", rom_addr_o, 32'h0);
        chk("wrap_c5_pc", if_pc_o, 32'hFFFF_FFFC);
        adv();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_c6_addr", rom_addr_o, 32'h4);
        chk("wrap_c6_pc", if_pc_o, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst2");

        // ---- misaligned redirect ----
        sb_q.push_back(32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        sb_q.push_back(32'h44);
`else
        sb_q.push_back(32'h40);
        sb_q.push_back(32'h44);
        sb_q.push_back(32'h44);
`endif
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        adv();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mis_c1_ce", {31'd0, rom_ce_o}, 32'd1);
        adv();
        step(1'b0, 1'b1, 32'h42, 1'b1);
        chk("mis_redir_ce", {31'd0, rom_ce_o}, 32'd0);
        adv();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk($sformatf("mis_hold%0d_ce", k),  {31'd0, rom_ce_o},   32'd0);
            chk($sformatf("mis_hold%0d_flag", k), {31'd0, misalign_o}, 32'd1);
`else
            chk($sformatf("mis_hold%0d_ce", k),  {31'd0, rom_ce_o},   32'd1);
            chk($sformatf("mis_hold%0d_addr", k), rom_addr_o, (k == 0) ? 32'h40 : 32'h44);
            chk($sformatf("mis_hold%0d_flag", k), {31'd0, misalign_o}, 32'd0);
`endif
            adv();
        end
        step(1'b0, 1'b1, 32'h44, 1'b1);
        chk("mis_redir2_ce", {31'd0, rom_ce_o}, 32'd0);
        adv();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mis_clear_flag", {31'd0, misalign_o}, 32'd0);
        chk("mis_clear_addr", rom_addr_o, 32'h44);
        adv();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mis_head_pc", if_pc_o, 32'h44);
        #1;
        rst_n = 1'b0;
        #1;

        chk("sb_left", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
